// File: rtl/hybrid_pkg.sv
// Shared types and constants for the hybrid phase-angle sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hybrid_pkg;

    typedef enum logic [1:0] {
        POS = 2'd0,
        ZA  = 2'd1,
        NEG = 2'd2,
        ZB  = 2'd3
    } state_t;

    // Raw/filtered jump conditions, c_pos in the MSB.
    typedef struct packed {
        logic c_pos;
        logic c_za;
        logic c_neg;
        logic c_zb;
    } cond_t;

    localparam logic [3:0] MOS_POS  = 4'b1001;
    localparam logic [3:0] MOS_ZERO = 4'b0011;
    localparam logic [3:0] MOS_NEG  = 4'b0110;

    localparam logic [1:0] SIG_POS  = 2'b01;
    localparam logic [1:0] SIG_ZERO = 2'b00;
    localparam logic [1:0] SIG_NEG  = 2'b11;

    function automatic int acc_width(input int data_w, input int mu_w, input int coef_w);
        return data_w + mu_w + coef_w + 2;
    endfunction

    function automatic logic [3:0] mos_of(input state_t s);
        case (s)
            POS:     return MOS_POS;
            NEG:     return MOS_NEG;
            default: return MOS_ZERO;
        endcase
    endfunction

    function automatic logic [1:0] sig_of(input state_t s);
        case (s)
            POS:     return SIG_POS;
            NEG:     return SIG_NEG;
            default: return SIG_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/hybrid_control_seq_jump_set_eval.sv
// Jump-set evaluator: full-precision products, then signed sums and sign extraction.
// Latency: 2 cycles from sample to raw condition bits (multiply stage, sum stage).
// Backpressure: none; accepts a new sample every cycle.
module jump_set_eval
    import hybrid_pkg::*;
#(
    parameter int              DATA_W = 14,
    parameter int              COEF_W = 32,
    parameter int              MU_W   = 32,
    parameter logic [MU_W-1:0] MU_Z1  = 86,
    parameter logic [MU_W-1:0] MU_Z2  = 90,
    parameter logic [MU_W-1:0] MU_VG  = 312000
) (
    input  logic                     i_clock,
    input  logic                     i_RESET,
    input  logic signed [DATA_W-1:0] vc,
    input  logic signed [DATA_W-1:0] ic,
    input  logic signed [COEF_W-1:0] cphi,
    input  logic signed [COEF_W-1:0] sphi,
    input  logic [1:0]               sigma,
    output logic [3:0]               cond
);

    localparam int ACC_W = acc_width(DATA_W, MU_W, COEF_W);
    localparam int PV_W  = DATA_W + MU_W + 1;
    localparam int T_W   = PV_W + 1;

    // Gains are unsigned; one extra zero bit makes them usable in signed products.
    localparam logic signed [MU_W:0] MU_Z1_S = {1'b0, MU_Z1};
    localparam logic signed [MU_W:0] MU_Z2_S = {1'b0, MU_Z2};
    localparam logic signed [MU_W:0] MU_VG_S = {1'b0, MU_VG};

    logic signed [PV_W-1:0]  z1_term, z2_term;
    logic signed [T_W-1:0]   vg_term, z1_net;
    logic signed [ACC_W-1:0] a_prod, b_prod, c_prod;
    logic signed [ACC_W-1:0] a_q, b_q, c_q;
    logic signed [ACC_W-1:0] s1, s2, s3;
    cond_t                   cond_d, cond_q;

    always_comb begin
        z1_term = PV_W'(MU_Z1_S) * PV_W'(vc);
        z2_term = PV_W'(MU_Z2_S) * PV_W'(ic);
        case (sigma)
            SIG_POS: vg_term = T_W'(MU_VG_S);
            SIG_NEG: vg_term = -T_W'(MU_VG_S);
            default: vg_term = '0;
        endcase
        z1_net = T_W'(z1_term) - vg_term;
        a_prod = ACC_W'(z1_net) * ACC_W'(sphi);
        b_prod = ACC_W'(z2_term) * ACC_W'(cphi);
        c_prod = ACC_W'(MU_VG_S) * ACC_W'(sphi);
    end

    always_comb begin
        s1 = a_q - b_q + c_q;
        s2 = a_q + b_q;
        s3 = a_q - b_q - c_q;
        cond_d.c_pos = ~s1[ACC_W-1];
        cond_d.c_za  =  s2[ACC_W-1];
        cond_d.c_neg =  s3[ACC_W-1];
        cond_d.c_zb  = ~s2[ACC_W-1];
    end

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            cond_q <= '0;
        end else begin
            a_q    <= a_prod;
            b_q    <= b_prod;
            c_q    <= c_prod;
            cond_q <= cond_d;
        end
    end

    assign cond = cond_q;

endmodule

// File: rtl/hybrid_control_seq.sv
// Hybrid phase-angle sequencer: jump-set pipeline, debounce, dwell timer, gate FSM; dead-time with HYBRID_DEADTIME_EN.
// Latency: sample to raw condition 2 cycles, raw condition to new state DEB_N+1 cycles.
// Backpressure: none; free-running sample stream, jumps held off while dwell (or dead-time) runs.
module hybrid_control_seq
    import hybrid_pkg::*;
#(
    parameter int              DATA_W    = 14,
    parameter int              COEF_W    = 32,
    parameter int              MU_W      = 32,
    parameter logic [MU_W-1:0] MU_Z1     = 86,
    parameter logic [MU_W-1:0] MU_Z2     = 90,
    parameter logic [MU_W-1:0] MU_VG     = 312000,
    parameter int              DEB_N     = 2,
    parameter int              MIN_DWELL = 500,
    parameter int              DEADTIME  = 8
) (
    input  logic                     i_clock,
    input  logic                     i_RESET,
    input  logic signed [DATA_W-1:0] i_vC,
    input  logic signed [DATA_W-1:0] i_iC,
    input  logic signed [COEF_W-1:0] i_cphi,
    input  logic signed [COEF_W-1:0] i_sphi,
    input  logic                     i_mode,
    output logic [3:0]               o_MOSFET,
    output logic [1:0]               o_sigma,
    output logic                     o_jump,
    output logic [1:0]               o_state
);

    localparam int DEB_W   = $clog2(DEB_N + 1);
    localparam int DWELL_W = $clog2(MIN_DWELL + 1);

    state_t                state, nxt;
    logic [3:0]            raw_bits, filt_bits;
    cond_t                 filt;
    logic [3:0][DEB_W-1:0] deb_cnt;
    logic [DWELL_W-1:0]    dwell;
    logic                  blocked;
    logic                  take;

    jump_set_eval #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .MU_W   (MU_W),
        .MU_Z1  (MU_Z1),
        .MU_Z2  (MU_Z2),
        .MU_VG  (MU_VG)
    ) u_eval (
        .i_clock (i_clock),
        .i_RESET (i_RESET),
        .vc      (i_vC),
        .ic      (i_iC),
        .cphi    (i_cphi),
        .sphi    (i_sphi),
        .sigma   (o_sigma),
        .cond    (raw_bits)
    );

    always_comb begin
        filt_bits = '0;
        for (int i = 0; i < 4; i++) filt_bits[i] = (deb_cnt[i] == DEB_W'(DEB_N));
    end
    assign filt = cond_t'(filt_bits);

`ifdef HYBRID_DEADTIME_EN
    localparam int DT_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
    logic [DT_W-1:0] dt_cnt;
    assign blocked = (dwell != '0) || (dt_cnt != '0);
`else
    // DEADTIME only has meaning in the dead-time build.
    logic unused_deadtime;
    assign unused_deadtime = |DEADTIME;
    assign blocked = (dwell != '0);
`endif

    // ZA and ZB always exit on their own condition, whatever the current mode.
    always_comb begin
        nxt = state;
        case (state)
            POS: if (filt.c_pos) nxt = i_mode ? NEG : ZA;
            ZA:  if (filt.c_za)  nxt = NEG;
            NEG: if (filt.c_neg) nxt = i_mode ? POS : ZB;
            ZB:  if (filt.c_zb)  nxt = POS;
            default: nxt = POS;
        endcase
    end

    assign take = !blocked && (nxt != state);

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state    <= POS;
            o_sigma  <= SIG_POS;
            o_MOSFET <= MOS_POS;
            o_jump   <= 1'b0;
            dwell    <= DWELL_W'(MIN_DWELL);
            deb_cnt  <= '0;
`ifdef HYBRID_DEADTIME_EN
            dt_cnt   <= '0;
`endif
        end else begin
            o_jump <= 1'b0;
            if (dwell != '0) dwell <= dwell - DWELL_W'(1);
            if (take) begin
                state   <= nxt;
                o_sigma <= sig_of(nxt);
                o_jump  <= 1'b1;
                dwell   <= DWELL_W'(MIN_DWELL);
                deb_cnt <= '0;
            end else begin
                // Counters stay cleared while jumps are blocked so each jump costs a full DEB_N.
                for (int i = 0; i < 4; i++) begin
                    if (blocked || !raw_bits[i])
                        deb_cnt[i] <= '0;
                    else if (deb_cnt[i] != DEB_W'(DEB_N))
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
`ifdef HYBRID_DEADTIME_EN
            if (take) begin
                dt_cnt   <= DT_W'(DEADTIME);
                o_MOSFET <= (DEADTIME < 1) ? mos_of(nxt) : (mos_of(state) & mos_of(nxt));
            end else if (dt_cnt != '0) begin
                dt_cnt <= dt_cnt - DT_W'(1);
                if (dt_cnt == DT_W'(1)) o_MOSFET <= mos_of(state);
            end
`else
            if (take) o_MOSFET <= mos_of(nxt);
`endif
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_hybrid_control_seq.sv
// Directed bench for hybrid_control_seq: reset, three/two-level cycles, debounce, dwell spacing, mode change, reset mid-dwell.
// Expected jumps are queued with their due cycle and popped when o_jump is seen; HYBRID_DEADTIME_EN adds dead-time checks.
module tb_hybrid_control_seq;
    import hybrid_pkg::*;

    localparam int DATA_W    = 14;
    localparam int COEF_W    = 32;
    localparam int DEB_N     = 2;
    localparam int MIN_DWELL = 8;
    localparam int DEADTIME  = 8;

    logic                     i_clock = 1'b0;
    logic                     i_RESET = 1'b1;
    logic signed [DATA_W-1:0] i_vC    = '0;
    logic signed [DATA_W-1:0] i_iC    = '0;
    logic signed [COEF_W-1:0] i_cphi  = 1;
    logic signed [COEF_W-1:0] i_sphi  = 1;
    logic                     i_mode  = 1'b0;
    logic [3:0]               o_MOSFET;
    logic [1:0]               o_sigma;
    logic                     o_jump;
    logic [1:0]               o_state;

    hybrid_control_seq #(
        .DEB_N     (DEB_N),
        .MIN_DWELL (MIN_DWELL),
        .DEADTIME  (DEADTIME)
    ) dut (
        .i_clock  (i_clock),
        .i_RESET  (i_RESET),
        .i_vC     (i_vC),
        .i_iC     (i_iC),
        .i_cphi   (i_cphi),
        .i_sphi   (i_sphi),
        .i_mode   (i_mode),
        .o_MOSFET (o_MOSFET),
        .o_sigma  (o_sigma),
        .o_jump   (o_jump),
        .o_state  (o_state)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] st;
        logic [1:0] sig;
        logic [3:0] mos;
        int         at;
    } exp_t;

    exp_t   sb[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    state_t cur      = POS;
    state_t prev     = POS;

    function automatic logic [3:0] mos_tab(input state_t s);
        case (s)
            POS:     return 4'b1001;
            NEG:     return 4'b0110;
            default: return 4'b0011;
        endcase
    endfunction

    function automatic logic [1:0] sig_tab(input state_t s);
        case (s)
            POS:     return 2'b01;
            NEG:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int vc, input int ic);
        i_vC = DATA_W'(vc);
        i_iC = DATA_W'(ic);
    endtask

    task automatic push_exp(input state_t nxt, input int at);
        exp_t e;
        e.st  = nxt;
        e.sig = sig_tab(nxt);
`ifdef HYBRID_DEADTIME_EN
        e.mos = mos_tab(cur) & mos_tab(nxt);
`else
        e.mos = mos_tab(nxt);
`endif
        e.at  = at;
        sb.push_back(e);
        prev = cur;
        cur  = nxt;
    endtask

    task automatic expect_jump(input string tag, input int budget);
        exp_t e;
        int   got = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clock);
            if (o_jump === 1'b1) begin
                got = cyc;
                break;
            end
        end
        e = sb.pop_front();
        check({tag, "_cycle"}, got, e.at);
        check({tag, "_state"}, o_state, e.st);
        check({tag, "_sigma"}, o_sigma, e.sig);
        check({tag, "_mosfet"}, o_MOSFET, e.mos);
    endtask

    task automatic idle(input string tag, input int n);
        int jumps = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge i_clock);
            if (k == 1) check({tag, "_jump_pulse"}, o_jump, 1'b0);
            if (o_jump === 1'b1) jumps++;
`ifdef HYBRID_DEADTIME_EN
            if (k == DEADTIME - 1) check({tag, "_dt_hold"}, o_MOSFET, mos_tab(prev) & mos_tab(cur));
            if (k == DEADTIME) check({tag, "_dt_release"}, o_MOSFET, mos_tab(cur));
`endif
        end
        check({tag, "_no_jump"}, jumps, 0);
    endtask

    // From a jump negedge: hold the current state's exit condition false until dwell expires, then trigger it.
    task automatic advance(input string tag, input state_t nxt,
                           input int nvc, input int nic, input int tvc, input int tic);
        drive(nvc, nic);
        idle(tag, MIN_DWELL + 2);
        drive(tvc, tic);
        push_exp(nxt, cyc + DEB_N + 3);
        expect_jump(tag, 40);
    endtask

    initial begin
        int t;

        // Reset with c_pos already true: first jump only after the reset dwell plus debounce.
        drive(100, 0);
        repeat (3) @(negedge i_clock);
        check("rst_mosfet", o_MOSFET, 4'b1001);
        check("rst_sigma", o_sigma, 2'b01);
        check("rst_jump", o_jump, 1'b0);
        check("rst_state", o_state, POS);
        i_RESET = 1'b0;
        push_exp(ZA, cyc + MIN_DWELL + DEB_N + 1);
        expect_jump("rst_pos_za", 40);

        // Three-level cycle.
        advance("za_neg", NEG, 0, 0, -100, 0);
        advance("neg_zb", ZB, 0, 0, -100, 0);
        advance("zb_pos", POS, 0, -100, 100, 0);

        // Two-level.
        i_mode = 1'b1;
        advance("pos_neg_2l", NEG, 0, 100, 100, 0);
        advance("neg_pos_2l", POS, 0, 0, -100, 0);

        // Debounce: raw c_pos 1,0,1,1.
        drive(0, 100);
        idle("deb_pre", MIN_DWELL + 2);
        t = cyc;
        drive(100, 0);
        @(negedge i_clock);
        drive(0, 100);
        @(negedge i_clock);
        drive(100, 0);
        push_exp(NEG, t + 2 + DEB_N + 3);
        expect_jump("deb_pos_neg", 40);

        // Dwell: exit condition true right after each jump.
        drive(-100, 0);
        push_exp(POS, cyc + MIN_DWELL + DEB_N + 1);
        expect_jump("dwell_neg_pos", 40);
        drive(100, 0);
        push_exp(NEG, cyc + MIN_DWELL + DEB_N + 1);
        expect_jump("dwell_pos_neg", 40);

        // Mode flips to two-level while in ZB: ZB still exits to POS.
        i_mode = 1'b0;
        advance("neg_zb_m0", ZB, 0, 0, -100, 0);
        i_mode = 1'b1;
        advance("zb_pos_m1", POS, 0, -100, 100, 0);

        // Reset three cycles into the dwell (and dead-time) after a jump.
        advance("pos_neg_pre_rst", NEG, 0, 100, 100, 0);
        repeat (3) @(negedge i_clock);
        i_RESET = 1'b1;
        @(negedge i_clock);
        check("midrst_mosfet", o_MOSFET, 4'b1001);
        check("midrst_sigma", o_sigma, 2'b01);
        check("midrst_state", o_state, POS);
        check("midrst_jump", o_jump, 1'b0);
        i_RESET = 1'b0;

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
